guess_input_encoder: RTL and testbench

//  Producer side of the game handler's guess interface. Consumes PS/2 set-2 scan-code bytes.

---
 rtl/guess_input_encoder.sv | 182 ++++++++++++++++++
 tb/tb_guess_input_encoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_input_encoder.sv
// Guess input encoder: PS/2 set-2 scan bytes to single-cycle guess loads.
// Filters breaks, typematic repeats, extended keys and duplicate guesses.
module guess_input_encoder #(
    parameter int          GAP_CYCLES = 16,
    parameter logic [7:0]  BREAK_CODE = 8'hF0,
    parameter logic [7:0]  EXT_CODE   = 8'hE0,
    parameter logic [7:0]  START_CODE = 8'h5A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_valid,
    input  logic [7:0]  scan_code,
    input  logic [1:0]  game_state,
    input  logic [25:0] guessed_mask,
    output logic        load,
    output logic [4:0]  load_x,
    output logic        dup_guess,
    output logic        key_held
);

    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_RELOAD = CW'(GAP_CYCLES - 1);
    localparam logic [4:0] START_IDX = 5'd26;

    typedef enum logic [1:0] {
        P_IDLE,
        P_BREAK,
        P_EXT,
        P_EXT_BREAK
    } pstate_t;

    pstate_t state, state_nxt;

    logic [7:0]    held_code;
    logic          make_seen, break_seen, new_make;
    logic          code_hit;
    logic [4:0]    code_idx;
    logic          ev_valid;
    logic [CW-1:0] gap_cnt;
    logic          pend_valid, pend_valid_nxt;
    logic [4:0]    pend_idx, pend_idx_nxt;
    logic          iss_valid;
    logic [4:0]    iss_idx;
    logic          do_load, do_dup;
    logic          in_game, is_start;
    logic [31:0]   mask_ext;

    // Parser state register
    always_ff @(posedge clk) begin
        if (reset) state <= P_IDLE;
        else       state <= state_nxt;
    end

    // Parser next state and make/break classification of the current byte
    always_comb begin
        state_nxt  = state;
        make_seen  = 1'b0;
        break_seen = 1'b0;
        if (scan_valid) begin
            case (state)
                P_IDLE: begin
                    if (scan_code == EXT_CODE)        state_nxt = P_EXT;
                    else if (scan_code == BREAK_CODE) state_nxt = P_BREAK;
                    else                              make_seen = 1'b1;
                end
                P_BREAK: begin
                    break_seen = 1'b1;
                    state_nxt  = P_IDLE;
                end
                P_EXT: begin
                    if (scan_code == BREAK_CODE) state_nxt = P_EXT_BREAK;
                    else                         state_nxt = P_IDLE;
                end
                default: state_nxt = P_IDLE;
            endcase
        end
    end

    assign new_make = make_seen && !(key_held && scan_code == held_code);

    // Map a make code to its letter index, or the start index
    always_comb begin
        code_hit = 1'b1;
        code_idx = 5'd0;
        if (scan_code == START_CODE) begin
            code_idx = START_IDX;
        end else begin
            case (scan_code)
                8'h1C: code_idx = 5'd0;
                8'h32: code_idx = 5'd1;
                8'h21: code_idx = 5'd2;
                8'h23: code_idx = 5'd3;
                8'h24: code_idx = 5'd4;
                8'h2B: code_idx = 5'd5;
                8'h34: code_idx = 5'd6;
                8'h33: code_idx = 5'd7;
                8'h43: code_idx = 5'd8;
                8'h3B: code_idx = 5'd9;
                8'h42: code_idx = 5'd10;
                8'h4B: code_idx = 5'd11;
                8'h3A: code_idx = 5'd12;
                8'h31: code_idx = 5'd13;
                8'h44: code_idx = 5'd14;
                8'h4D: code_idx = 5'd15;
                8'h15: code_idx = 5'd16;
                8'h2D: code_idx = 5'd17;
                8'h1B: code_idx = 5'd18;
                8'h2C: code_idx = 5'd19;
                8'h3C: code_idx = 5'd20;
                8'h2A: code_idx = 5'd21;
                8'h1D: code_idx = 5'd22;
                8'h22: code_idx = 5'd23;
                8'h35: code_idx = 5'd24;
                8'h1A: code_idx = 5'd25;
                default: code_hit = 1'b0;
            endcase
        end
    end

    assign ev_valid = new_make && code_hit;

    // Held key tracking: latch on accepted make, release on matching break
    always_ff @(posedge clk) begin
        if (reset) begin
            held_code <= 8'h00;
            key_held  <= 1'b0;
        end else if (new_make) begin
            held_code <= scan_code;
            key_held  <= 1'b1;
        end else if (break_seen && scan_code == held_code) begin
            key_held  <= 1'b0;
        end
    end

    // Choose what issues this edge: pending first, else a fresh event
    always_comb begin
        iss_valid      = 1'b0;
        iss_idx        = 5'd0;
        pend_valid_nxt = pend_valid;
        pend_idx_nxt   = pend_idx;
        if (gap_cnt == '0 && pend_valid) begin
            iss_valid      = 1'b1;
            iss_idx        = pend_idx;
            pend_valid_nxt = ev_valid;
            pend_idx_nxt   = code_idx;
        end else if (gap_cnt == '0 && ev_valid) begin
            iss_valid = 1'b1;
            iss_idx   = code_idx;
        end else if (ev_valid) begin
            pend_valid_nxt = 1'b1;
            pend_idx_nxt   = code_idx;
        end
    end

    assign in_game  = (game_state == 2'd1);
    assign is_start = (iss_idx == START_IDX);
    assign mask_ext = {6'd0, guessed_mask};
    assign do_load  = iss_valid &&
                      (is_start ? !in_game : (in_game && !mask_ext[iss_idx]));
    assign do_dup   = iss_valid && !is_start && in_game && mask_ext[iss_idx];

    // Issue registers, pending slot and load spacing counter
    always_ff @(posedge clk) begin
        if (reset) begin
            load       <= 1'b0;
            load_x     <= 5'd0;
            dup_guess  <= 1'b0;
            gap_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= 5'd0;
        end else begin
            load       <= do_load;
            dup_guess  <= do_dup;
            pend_valid <= pend_valid_nxt;
            pend_idx   <= pend_idx_nxt;
            if (do_load) load_x <= iss_idx;
            if (do_load)             gap_cnt <= GAP_RELOAD;
            else if (gap_cnt != '0)  gap_cnt <= gap_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_guess_input_encoder.sv
// Bench for guess_input_encoder: directed scenarios plus random byte
// streams checked every cycle against a packet-level reference model.
module tb_guess_input_encoder;

    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic [1:0]  game_state;
    logic [25:0] guessed_mask;
    logic        load;
    logic [4:0]  load_x;
    logic        dup_guess;
    logic        key_held;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int loads[$];
    int dups  = 0;

    logic [7:0] lt [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                            8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                            8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    // Reference model state
    logic [7:0] pkt[$];
    bit         m_held;
    logic [7:0] m_code;
    bit         m_pend;
    int         m_pidx;
    longint     last_load;
    bit         e_load, e_dup;
    logic [4:0] e_x;

    guess_input_encoder #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .scan_valid(scan_valid),
        .scan_code(scan_code), .game_state(game_state),
        .guessed_mask(guessed_mask), .load(load), .load_x(load_x),
        .dup_guess(dup_guess), .key_held(key_held)
    );

    always #5 clk = ~clk;

    function automatic int lookup(input logic [7:0] c);
        for (int i = 0; i < 26; i++) if (lt[i] == c) return i;
        if (c == 8'h5A) return 26;
        return -1;
    endfunction

    task automatic model(input bit r, input bit v, input logic [7:0] c);
        int ev, iss, n;
        bit done;
        ev = -1;
        iss = -1;
        if (r) begin
            pkt.delete();
            m_held = 0; m_code = 0; m_pend = 0; m_pidx = 0;
            last_load = -1000;
            e_load = 0; e_dup = 0; e_x = 0;
            return;
        end
        if (v) begin
            pkt.push_back(c);
            n = pkt.size();
            if (pkt[0] == 8'hF0)      done = (n == 2);
            else if (pkt[0] == 8'hE0) done = (n == 3) || (n == 2 && pkt[1] != 8'hF0);
            else                      done = 1;
            if (done) begin
                if (n == 1) begin
                    if (!(m_held && pkt[0] == m_code)) begin
                        m_code = pkt[0];
                        m_held = 1;
                        ev = lookup(pkt[0]);
                    end
                end else if (pkt[0] == 8'hF0) begin
                    if (pkt[1] == m_code) m_held = 0;
                end
                pkt.delete();
            end
        end
        if (longint'(cyc) + 1 >= last_load + GAP) begin
            if (m_pend) begin
                iss = m_pidx;
                m_pend = (ev >= 0);
                m_pidx = ev;
            end else begin
                iss = ev;
            end
        end else if (ev >= 0) begin
            m_pend = 1;
            m_pidx = ev;
        end
        e_load = 0;
        e_dup = 0;
        if (iss == 26) e_load = (game_state != 2'd1);
        else if (iss >= 0 && game_state == 2'd1) begin
            if (guessed_mask[iss]) e_dup = 1;
            else e_load = 1;
        end
        if (e_load) begin
            e_x = 5'(iss);
            last_load = longint'(cyc) + 1;
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] c);
        reset = r;
        scan_valid = v;
        scan_code = c;
        model(r, v, c);
        @(posedge clk);
        #1;
        cyc++;
        if (load) loads.push_back(cyc);
        if (dup_guess) dups++;
        total++;
        assert (load === e_load) else begin
            bad++; $error("FAIL load: got %0b exp %0b cyc %0d", load, e_load, cyc);
        end
        total++;
        assert (load_x === e_x) else begin
            bad++; $error("FAIL load_x: got %0d exp %0d cyc %0d", load_x, e_x, cyc);
        end
        total++;
        assert (dup_guess === e_dup) else begin
            bad++; $error("FAIL dup: got %0b exp %0b cyc %0d", dup_guess, e_dup, cyc);
        end
        total++;
        assert (key_held === m_held) else begin
            bad++; $error("FAIL key_held: got %0b exp %0b cyc %0d", key_held, m_held, cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00);
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++; $error("FAIL %s: got %0d exp %0d", tag, got, exp);
        end
    endtask

    initial begin
        logic [7:0] c;
        game_state = 2'd1;
        guessed_mask = '0;
        // Reset state
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        chk("rst_load", int'(load), 0);
        chk("rst_x", int'(load_x), 0);

        // T1: single letter
        step(0, 1, 8'h1C);
        chk("t1_load", int'(load), 1);
        chk("t1_x", int'(load_x), 0);
        idle(1);
        chk("t1_pulse", int'(load), 0);
        idle(20);

        // T2: typematic repeat filtering
        step(1, 0, 8'h00);
        loads.delete();
        foreach (lt[i]) if (i < 6) begin
            c = (i == 3) ? 8'hF0 : 8'h1C;
            step(0, 1, c);
            idle(17);
        end
        chk("t2_loads", loads.size(), 2);
        chk("t2_held", int'(key_held), 1);

        // T3: duplicate guess, gap untouched
        step(1, 0, 8'h00);
        guessed_mask = 26'h10;
        dups = 0;
        step(0, 1, 8'h24);
        chk("t3_dup", int'(dup_guess), 1);
        chk("t3_noload", int'(load), 0);
        step(0, 1, 8'h1C);
        chk("t3_nogap", int'(load), 1);
        idle(20);
        chk("t3_dups", dups, 1);
        guessed_mask = '0;

        // T4: spacing between loads
        step(1, 0, 8'h00);
        loads.delete();
        step(0, 1, 8'h1C);
        step(0, 1, 8'hF0);
        step(0, 1, 8'h1C);
        step(0, 1, 8'h32);
        idle(30);
        chk("t4_loads", loads.size(), 2);
        if (loads.size() == 2) chk("t4_gap", loads[1] - loads[0], GAP);
        chk("t4_x", int'(load_x), 1);

        // T5: start key and extended keys
        game_state = 2'd0;
        step(1, 0, 8'h00);
        step(0, 1, 8'h5A);
        chk("t5_start", int'(load_x), 26);
        idle(20);
        game_state = 2'd1;
        loads.delete();
        step(0, 1, 8'hF0); step(0, 1, 8'h5A); step(0, 1, 8'h5A);
        step(0, 1, 8'hE0); step(0, 1, 8'h75); step(0, 1, 8'hE0);
        step(0, 1, 8'hF0); step(0, 1, 8'h75);
        idle(20);
        chk("t5_noload", loads.size(), 0);

        // T6: reset drops pending event
        step(1, 0, 8'h00);
        step(0, 1, 8'h1C);
        step(0, 1, 8'h1A);
        step(1, 0, 8'h00);
        loads.delete();
        idle(25);
        chk("t6_noload", loads.size(), 0);
        step(0, 1, 8'h1A);
        chk("t6_load", int'(load), 1);
        chk("t6_x", int'(load_x), 25);

        // Random streams
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) game_state = 2'($urandom);
            if ($urandom_range(0, 63) == 0)
                guessed_mask = ($urandom_range(0, 1) == 0) ? '0 : 26'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = lt[$urandom_range(0, 25)];
                4:          c = 8'h5A;
                5, 6:       c = 8'hF0;
                7:          c = 8'hE0;
                8:          c = 8'h75;
                default:    c = 8'($urandom);
            endcase
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
